// File: rtl/lbist_pkg.sv
// Shared types and step functions for the multi-chain logic-BIST controller.
// Step functions work on a fixed-width container; callers zero-extend and slice.
package lbist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHIFT,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_COMPARE,
      ST_DONE
   } state_e;

   localparam int unsigned MAX_W = 64;

   localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] DEF_LFSR_SEED = 32'h0000_0001;
   localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

   // Galois right shift; upper unused bits stay zero as long as poly fits the width.
   function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s,
                                                  input logic [MAX_W-1:0] poly);
      return (s >> 1) ^ (s[0] ? poly : '0);
   endfunction

   function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] s,
                                                  input logic [MAX_W-1:0] poly,
                                                  input logic [MAX_W-1:0] din,
                                                  input int unsigned      w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] msb;
      logic [MAX_W-1:0] nxt;
      mask = {MAX_W{1'b1}} >> (MAX_W - w);
      msb  = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
      nxt  = (s << 1) ^ din;
      if (|(s & msb)) nxt = nxt ^ poly;
      return nxt & mask;
   endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: compacts din each enabled cycle, clear has priority.
// Single-cycle update; no backpressure, caller gates with en.
module lbist_misr
   import lbist_pkg::*;
#(
   parameter int unsigned     W    = 32,
   parameter logic [W-1:0]    POLY = W'(DEF_MISR_POLY)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sig
);

   logic [MAX_W-1:0] nxt;

   assign nxt = misr_step(MAX_W'(sig), MAX_W'(POLY), MAX_W'(din), W);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  sig <= '0;
      else if (clr) sig <= '0;
      else if (en)  sig <= nxt[W-1:0];
   end

endmodule

// File: rtl/lbist_mc_ctrl.sv
// Multi-chain LBIST controller: LFSR-fed scan shift/capture sequencing with MISR compaction.
// Start edge to INIT takes one cycle; dropping start mid-run aborts to IDLE on the next edge.
module lbist_mc_ctrl
   import lbist_pkg::*;
#(
   parameter int unsigned        N_CHAINS   = 4,
   parameter int unsigned        CHAIN_LEN  = 64,
   parameter int unsigned        N_PATTERNS = 1024,
   parameter int unsigned        LFSR_W     = 32,
   parameter logic [LFSR_W-1:0]  LFSR_POLY  = LFSR_W'(DEF_LFSR_POLY),
   parameter logic [LFSR_W-1:0]  LFSR_SEED  = LFSR_W'(DEF_LFSR_SEED),
   parameter int unsigned        MISR_W     = 32,
   parameter logic [MISR_W-1:0]  MISR_POLY  = MISR_W'(DEF_MISR_POLY)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic [MISR_W-1:0]                 golden_sig_i,
   input  logic [N_CHAINS-1:0]               scan_out_i,
   output logic                              test_mode_o,
   output logic                              scan_en_o,
   output logic [N_CHAINS-1:0]               scan_in_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              go_nogo_o,
   output logic [MISR_W-1:0]                 signature_o,
   output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt_o
);

   localparam int unsigned      PC_W    = $clog2(N_PATTERNS + 1);
   localparam int unsigned      BC_W    = $clog2(CHAIN_LEN);
   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(CHAIN_LEN - 1);
   localparam logic [PC_W-1:0]  PC_LAST = PC_W'(N_PATTERNS - 1);

   state_e            state_q, state_d;
   logic              start_q, start_rise;
   logic [LFSR_W-1:0] lfsr_q;
   logic [MAX_W-1:0]  lfsr_nx;
   logic [BC_W-1:0]   bit_cnt_q;
   logic [PC_W-1:0]   pat_cnt_q;
   logic              pass_q;
   logic              shift_last, run_phase, shifting;
   logic              misr_en, misr_clr;

   assign start_rise = start_i & ~start_q;
   assign shift_last = (bit_cnt_q == BC_LAST);
   assign run_phase  = state_q inside {ST_INIT, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_COMPARE};
   assign shifting   = state_q inside {ST_SHIFT, ST_UNLOAD};
   assign lfsr_nx    = lfsr_step(MAX_W'(lfsr_q), MAX_W'(LFSR_POLY));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_rise) state_d = ST_INIT;
         ST_INIT:    state_d = ST_SHIFT;
         ST_SHIFT:   if (shift_last) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = (pat_cnt_q == PC_LAST) ? ST_UNLOAD : ST_SHIFT;
         ST_UNLOAD:  if (shift_last) state_d = ST_COMPARE;
         ST_COMPARE: state_d = ST_DONE;
         ST_DONE:    if (start_rise) state_d = ST_INIT;
         default:    state_d = ST_IDLE;
      endcase
      if (run_phase && !start_i) state_d = ST_IDLE;
   end

   always_comb begin
      test_mode_o   = (state_q != ST_IDLE);
      busy_o        = run_phase;
      scan_en_o     = shifting;
      scan_in_o     = shifting ? lfsr_q[N_CHAINS-1:0] : '0;
      done_o        = (state_q == ST_DONE);
      go_nogo_o     = (state_q == ST_DONE) & pass_q;
      pattern_cnt_o = pat_cnt_q;
   end

   // Reset start_q high so a start held across reset release is not taken as an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q   <= 1'b1;
         lfsr_q    <= LFSR_SEED;
         bit_cnt_q <= '0;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         start_q <= start_i;
         if (state_d == ST_IDLE) begin
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
            pass_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_INIT: begin
                  lfsr_q    <= LFSR_SEED;
                  bit_cnt_q <= '0;
                  pat_cnt_q <= '0;
                  pass_q    <= 1'b0;
               end
               ST_SHIFT, ST_UNLOAD: begin
                  lfsr_q    <= lfsr_nx[LFSR_W-1:0];
                  bit_cnt_q <= shift_last ? '0 : bit_cnt_q + 1'b1;
               end
               ST_CAPTURE: pat_cnt_q <= pat_cnt_q + 1'b1;
               ST_COMPARE: pass_q    <= (signature_o == golden_sig_i);
               default: ;
            endcase
         end
      end
   end

   // The first load only flushes power-on chain contents, so it is not compacted.
   assign misr_en  = ((state_q == ST_SHIFT) && (pat_cnt_q != '0)) || (state_q == ST_UNLOAD);
   assign misr_clr = (state_q == ST_INIT) || (state_d == ST_IDLE);

   lbist_misr #(
      .W    (MISR_W),
      .POLY (MISR_POLY)
   ) u_misr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (misr_clr),
      .en     (misr_en),
      .din    (MISR_W'(scan_out_i)),
      .sig    (signature_o)
   );

endmodule

// File: doc/lbist_mc_ctrl.md
# lbist_mc_ctrl

Parametrised multi-channel logic-BIST controller that sits between the testbench/SoC `start`/`go_nogo` handshake and the scan-inserted RI5CY core. It drives N parallel scan chains from an LFSR pattern generator, sequences shift/capture, and compacts chain responses into a MISR. It compares the final signature against a run-time golden value and reports pass/fail on a held `go_nogo` level. It generalises the single-chain, fixed-signature LBIST with chain count, chain length, pattern count, polynomial widths, abort-on-deassert and a readable signature.

## Interface
- `N_CHAINS`, 4: parallel scan chains, 1..MISR_W.
- `CHAIN_LEN`, 64: flops per chain (longest chain), ≥2.
- `N_PATTERNS`, 1024: capture patterns per run, ≥1.
- `LFSR_W`, 32: PRPG width, ≥ N_CHAINS.
- `LFSR_POLY`, 32'h8020_0003: Galois feedback taps.
- `LFSR_SEED`, 32'h0000_0001: non-zero seed.
- `MISR_W`, 32: signature width.
- `MISR_POLY`, 32'h04C1_1DB7: MISR feedback taps.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: level request; rising edge launches a run, low aborts or acknowledges.
- `golden_sig_i` in MISR_W: expected signature, sampled in COMPARE.
- `scan_out_i` in N_CHAINS: chain serial outputs.
- `test_mode_o` out 1: core in BIST mode (high from INIT through DONE).
- `scan_en_o` out 1: shift enable.
- `scan_in_o` out N_CHAINS: chain serial inputs.
- `busy_o` out 1: run in progress (INIT..COMPARE).
- `done_o` out 1: result valid.
- `go_nogo_o` out 1: `done_o & pass`.
- `signature_o` out MISR_W: current MISR value.
- `pattern_cnt_o` out $clog2(N_PATTERNS+1): captures completed.

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE: all outputs 0. Rising edge of `start_i` (registered edge detect) → INIT.
- INIT (1 cycle): LFSR ← LFSR_SEED, MISR ← 0, counters ← 0 → SHIFT.
- SHIFT (CHAIN_LEN cycles): `scan_en_o`=1, `scan_in_o`=LFSR[N_CHAINS-1:0], LFSR steps once per cycle. MISR compacts `scan_out_i` only when pattern_cnt ≥1 (first load unloads reset state, not compacted) → CAPTURE.
- CAPTURE (1 cycle): `scan_en_o`=0, LFSR and MISR hold, pattern_cnt++. If pattern_cnt reaches N_PATTERNS → UNLOAD, else → SHIFT.
- UNLOAD (CHAIN_LEN cycles): as SHIFT, MISR always compacts → COMPARE.
- COMPARE (1 cycle): pass ← (MISR == `golden_sig_i`) → DONE.
- DONE: `done_o`=1, `go_nogo_o`=pass, `test_mode_o`=1. Holds while `start_i` high and after it falls. Next `start_i` rising edge → INIT. Result cleared at INIT.
- Abort: `start_i` low in any of INIT..COMPARE → IDLE next cycle, `done_o`/`go_nogo_o` stay 0.
- MISR step: next = {misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended `scan_out_i`.
- LFSR step: Galois right shift. lfsr>>1, XOR LFSR_POLY when lfsr[0]=1.

## Timing
- Reset: all outputs and state 0, LFSR = LFSR_SEED, MISR = 0, state IDLE.
- Start edge at cycle t → INIT at t+1 (edge-detect register).
- Run length INIT→DONE entry: 1 + N_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
- `done_o`/`go_nogo_o` rise on the first DONE cycle, registered. Never glitch high during a run.
- `scan_in_o`/`scan_en_o` are registered and valid on the same cycle as the state. The chain samples them at the next edge. `scan_out_i` is sampled on the same edge.
- Start held high through reset release: no run until a fresh rising edge.

## Structure
- `lbist_pkg`: state enum, default polynomial/seed constants, MISR/LFSR step functions.
- Sub-module `lbist_misr` (parametrised width/poly, enable, clear) instantiated once. LFSR and FSM are inline.

## Test plan
- N_CHAINS=1, CHAIN_LEN=4, N_PATTERNS=2, scan_out tied 0, golden=0: start edge → `done_o` after 16 cycles, `go_nogo_o`=1.
- Same config with scan_out_i=1 constant: signature equals the software model computed over 8 compacted cycles. Golden equal → pass. Golden ^1 → `go_nogo_o`=0, `done_o`=1.
- N_CHAINS=4, chain model = 4×64 shift registers with XOR capture: `scan_in_o` sequence matches the LFSR model from seed 1. Golden from model → pass.
- Abort: drop `start_i` at pattern 3 → IDLE next cycle, `busy_o`=0, `done_o`=0. Restart → clean full-length run, same signature.
- DONE hold: deassert `start_i` 2 cycles after `go_nogo_o` rises → still 1. Re-raise `start_i` → cleared in INIT, new run.
- Async reset mid-SHIFT: all outputs 0 immediately. `start_i` held high across reset → no run until it toggles.
